// File: rtl/updown_pkg.sv
// Shared constants and helpers for the parametrised up/down counter and its prescaler.
// Direction and mode encodings are exported so surrounding logic can drive them by name.
package updown_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Prescaler width; a divide-by-1 still needs one (constant) bit of state.
  function automatic int pre_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/updown_counter_param_tick_prescaler.sv
// Integer clock-enable prescaler: one tick every DIV cycles with en high.
// restart zeroes the phase; en low freezes it.
module tick_prescaler
  import updown_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PRE_W = pre_width(DIV);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  assign tick = en && !restart && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (restart) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate bounds, clear, load, prescaled
// enable, a registered step/wrap pulse and sticky overflow/underflow flags.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int               DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tick;

  tick_prescaler #(
    .DIV(DIV)
  ) u_pre (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(clr | load),
    .tick   (tick)
  );

  // Bounds are decided against MAX_VAL so non-power-of-2 moduli wrap correctly.
  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (tick) begin
      step_d = 1'b1;
      if (up_dn == DIR_UP) begin
        if (count_q == MAX_VAL) begin
          ovf_d = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          unf_d = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            count_d = MAX_VAL;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus hand-computed directed expectations.
module tb_updown_counter_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       sat_mode;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       clr_flags;

  logic [3:0] d_cnt [3];
  logic       d_step[3];
  logic       d_wrap[3];
  logic       d_ovf [3];
  logic       d_unf [3];

  int n_checks;
  int n_fail;
  bit chk_en;

  // Model state: instance 0 = mod 10 /1, instance 1 = mod 16 /3, instance 2 = mod 10 /4.
  int m_max[3] = '{9, 15, 9};
  int m_div[3] = '{1, 3, 4};
  int m_cnt[3];
  int m_pre[3];
  bit m_step[3];
  bit m_wrap[3];
  bit m_ovf[3];
  bit m_unf[3];

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .DIV(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(d_cnt[0]), .step(d_step[0]), .wrap(d_wrap[0]), .ovf(d_ovf[0]), .unf(d_unf[0]));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd15), .DIV(3)) u1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(d_cnt[1]), .step(d_step[1]), .wrap(d_wrap[1]), .ovf(d_ovf[1]), .unf(d_unf[1]));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .DIV(4)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(d_cnt[2]), .step(d_step[2]), .wrap(d_wrap[2]), .ovf(d_ovf[2]), .unf(d_unf[2]));

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modular arithmetic for wrap, min/max for saturation.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_step[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end else begin
        m_step[i] = 0;
        m_wrap[i] = 0;
        if (clr_flags) begin
          m_ovf[i] = 0;
          m_unf[i] = 0;
        end
        if (clr) begin
          m_cnt[i] = 0;
          m_pre[i] = 0;
        end else if (load) begin
          m_cnt[i] = (int'(load_val) > m_max[i]) ? m_max[i] : int'(load_val);
          m_pre[i] = 0;
        end else if (en) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] == m_div[i]) begin
            m_pre[i] = 0;
            m_step[i] = 1;
            if (up_dn) begin
              if (m_cnt[i] == m_max[i]) begin
                m_ovf[i] = 1;
                m_wrap[i] = !sat_mode;
              end
              m_cnt[i] = sat_mode ? ((m_cnt[i] + 1 > m_max[i]) ? m_max[i] : m_cnt[i] + 1)
                                  : (m_cnt[i] + 1) % (m_max[i] + 1);
            end else begin
              if (m_cnt[i] == 0) begin
                m_unf[i] = 1;
                m_wrap[i] = !sat_mode;
              end
              m_cnt[i] = sat_mode ? ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1)
                                  : (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
            end
          end
        end
      end
    end
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_cnt[%0d]", i), 32'(d_cnt[i]), 32'(m_cnt[i]));
        chk($sformatf("model_step[%0d]", i), 32'(d_step[i]), 32'(m_step[i]));
        chk($sformatf("model_wrap[%0d]", i), 32'(d_wrap[i]), 32'(m_wrap[i]));
        chk($sformatf("model_ovf[%0d]", i), 32'(d_ovf[i]), 32'(m_ovf[i]));
        chk($sformatf("model_unf[%0d]", i), 32'(d_unf[i]), 32'(m_unf[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed stimulus with hand-computed expectations
  initial begin
    int e_cnt[4];
    int e_wrap[4];
    int e_ovf[4];
    n_checks = 0;
    n_fail = 0;
    chk_en = 0;
    rst = 0; en = 0; up_dn = 1; sat_mode = 0; clr = 0; load = 0; load_val = 0; clr_flags = 0;
    cyc(2);
    chk_en = 1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_cnt[%0d]", i), 32'(d_cnt[i]), 0);
      chk($sformatf("reset_flags[%0d]", i), 32'({d_step[i], d_wrap[i], d_ovf[i], d_unf[i]}), 0);
    end

    // Mod-10 up wrap from 7
    rst = 1; load = 1; load_val = 4'd7;
    cyc(1);
    chk("load7", 32'(d_cnt[0]), 7);
    load = 0; en = 1;
    e_cnt = '{8, 9, 0, 1};
    e_wrap = '{0, 0, 1, 0};
    e_ovf = '{0, 0, 1, 1};
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk($sformatf("upwrap_cnt%0d", k), 32'(d_cnt[0]), 32'(e_cnt[k]));
      chk($sformatf("upwrap_wrap%0d", k), 32'(d_wrap[0]), 32'(e_wrap[k]));
      chk($sformatf("upwrap_ovf%0d", k), 32'(d_ovf[0]), 32'(e_ovf[k]));
    end

    // Saturating down from 1
    en = 0; up_dn = 0; sat_mode = 1; load = 1; load_val = 4'd1;
    cyc(1);
    load = 0; en = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk($sformatf("satdn_cnt%0d", k), 32'(d_cnt[0]), 0);
      chk($sformatf("satdn_wrap%0d", k), 32'(d_wrap[0]), 0);
    end
    chk("satdn_unf", 32'(d_unf[0]), 1);
    chk("ovf_sticky", 32'(d_ovf[0]), 1);
    en = 0; clr_flags = 1;
    cyc(1);
    chk("unf_cleared", 32'(d_unf[0]), 0);
    clr_flags = 0;

    // Divide-by-3 cadence, then en gap of 2 cycles
    clr = 1;
    cyc(1);
    clr = 0; up_dn = 1; sat_mode = 0; en = 1;
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      chk($sformatf("div3_cnt%0d", k), 32'(d_cnt[1]), 32'(k / 3));
      chk($sformatf("div3_step%0d", k), 32'(d_step[1]), 32'((k % 3) == 0));
    end
    cyc(1);
    en = 0;
    cyc(2);
    chk("div3_gap_step", 32'(d_step[1]), 0);
    en = 1;
    cyc(1);
    chk("div3_gap_nostep", 32'(d_step[1]), 0);
    cyc(1);
    chk("div3_gap_cnt", 32'(d_cnt[1]), 4);
    chk("div3_gap_step2", 32'(d_step[1]), 1);

    // Priority: reset over clr/load, clr over load, load clamps
    en = 0; rst = 0; clr = 1; load = 1; load_val = 4'd5;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("prio_rst_cnt[%0d]", i), 32'(d_cnt[i]), 0);
      chk($sformatf("prio_rst_flags[%0d]", i), 32'({d_ovf[i], d_unf[i]}), 0);
    end
    rst = 1;
    cyc(1);
    chk("prio_clr_cnt", 32'(d_cnt[0]), 0);
    clr = 0; load_val = 4'd12;
    cyc(1);
    chk("load_clamp", 32'(d_cnt[0]), 9);
    chk("load_noclamp", 32'(d_cnt[1]), 12);
    load = 0;

    // Flag race: set beats clr_flags
    sat_mode = 1; up_dn = 1; en = 1; clr_flags = 1;
    cyc(1);
    chk("race_ovf", 32'(d_ovf[0]), 1);
    chk("race_cnt", 32'(d_cnt[0]), 9);
    chk("race_step", 32'(d_step[0]), 1);
    en = 0;
    cyc(1);
    chk("race_ovf_clr", 32'(d_ovf[0]), 0);
    clr_flags = 0;

    // Mod-10 down wrap from 0
    clr = 1;
    cyc(1);
    clr = 0; up_dn = 0; sat_mode = 0; en = 1;
    cyc(1);
    chk("dnwrap_cnt", 32'(d_cnt[0]), 9);
    chk("dnwrap_wrap", 32'(d_wrap[0]), 1);
    chk("dnwrap_unf", 32'(d_unf[0]), 1);
    en = 0;
    cyc(1);
    chk("dnwrap_wrap_clr", 32'(d_wrap[0]), 0);

    // Reset mid-period on divide-by-4 drops prescaler phase
    clr = 1;
    cyc(1);
    clr = 0; up_dn = 1; en = 1;
    cyc(2);
    rst = 0;
    cyc(1);
    rst = 1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk($sformatf("rstmid_step%0d", k), 32'(d_step[2]), 32'(k == 4));
      chk($sformatf("rstmid_cnt%0d", k), 32'(d_cnt[2]), 32'(k == 4));
    end

    // Mixed directed pattern, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      en        = (i % 5) != 4;
      up_dn     = ((i / 13) % 2) == 0;
      sat_mode  = ((i / 29) % 2) == 1;
      clr_flags = (i % 17) == 16;
      load      = (i % 23) == 22;
      load_val  = 4'(i % 16);
      clr       = (i == 50);
      cyc(1);
    end
    en = 0; load = 0; clr = 0; clr_flags = 0;
    cyc(1);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
